daq_multi_seq: RTL and testbench

Multi-channel acquisition sequencer for the data acquisition system. Each rising edge on `load` scans the enabled channels in ascending index order and emits one buffer write per channel. Write address, fill count and full status are generated internally, so no external address counter is needed. Stop is either automatic when the buffer is full (single-shot) or by request with address wrap (continuous). The block sits between the ADC channel registers and the sample RAM, on the divided clock domain.

---
 rtl/daq_multi_seq.sv | 194 +++++++++++++++++++
 tb/tb_daq_multi_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/daq_multi_seq.sv
// Multi-channel acquisition sequencer: each load edge scans the enabled channels
// in ascending order and writes one sample per channel into the sample buffer.
module daq_multi_seq #(
  parameter int DATA_W = 8,
  parameter int CH_N   = 4,
  parameter int DEPTH  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic                   new_clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [CH_N-1:0]        ch_mask,
  input  logic [CH_N*DATA_W-1:0] ch_data,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [CW-1:0]          wr_ch,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_load_q;
  logic                r_mode;
  logic                r_stop_pend;
  logic [CH_N-1:0]     r_pending;
  logic [AW-1:0]       r_ptr;
  logic [AW:0]         r_count;
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [CW-1:0]       r_wr_ch;
  logic                r_full;
  logic                r_busy;
  logic                r_done;
  logic                r_overrun;

  logic                w_trig;
  logic                w_stop_eff;
  logic                w_stop_set;
  logic [CW-1:0]       w_sel_idx;
  logic [CH_N-1:0]     w_sel_hot;
  logic [CH_N-1:0]     w_remain;
  logic                w_last;
  logic                w_write;
  logic                w_start;
  logic                w_rescan;
  logic                w_set_ovr;
  logic [AW:0]         w_count_nxt;
  logic [AW-1:0]       w_ptr_nxt;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_trig = load && !r_load_q && (ch_mask != '0);

  // A stop seen in the current cycle acts at once so a WAIT stop ends the run on the next edge.
  assign w_stop_eff = r_stop_pend || (stop && r_mode);
  assign w_stop_set = stop && r_mode && ((r_state == SCAN) || (r_state == WAIT));

  always_comb begin
    w_sel_idx = '0;
    w_sel_hot = '0;
    for (int c = CH_N - 1; c >= 0; c--) begin
      if (r_pending[c]) begin
        w_sel_idx    = CW'(c);
        w_sel_hot    = '0;
        w_sel_hot[c] = 1'b1;
      end
    end
  end

  assign w_remain    = r_pending & ~w_sel_hot;
  assign w_last      = (w_remain == '0);
  assign w_sel_data  = ch_data[int'(w_sel_idx)*DATA_W +: DATA_W];
  assign w_count_nxt = (r_count == CNT_FULL) ? r_count : r_count + (AW+1)'(1);
  assign w_ptr_nxt   = (r_ptr == LAST_ADDR) ? '0 : r_ptr + AW'(1);

  always_comb begin
    w_next    = r_state;
    w_write   = 1'b0;
    w_start   = 1'b0;
    w_rescan  = 1'b0;
    w_set_ovr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_next  = SCAN;
          w_start = 1'b1;
        end
      end
      SCAN: begin
        w_write   = 1'b1;
        w_set_ovr = w_trig;
        // Single-shot ends on the last buffer slot, dropping the rest of the scan.
        if (!r_mode && (r_ptr == LAST_ADDR)) begin
          w_next = DONE;
        end else if (w_last) begin
          w_next = w_stop_eff ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (w_stop_eff) begin
          w_next = DONE;
        end else if (w_trig) begin
          w_next   = SCAN;
          w_rescan = 1'b1;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge new_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge new_clk or posedge reset) begin
    if (reset) begin
      r_load_q    <= 1'b0;
      r_mode      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_ch     <= '0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_load_q <= load;
      r_busy   <= (w_next != IDLE);
      r_done   <= (w_next == DONE);
      r_wr_en  <= w_write;
      if (w_start) begin
        r_mode      <= mode;
        r_pending   <= ch_mask;
        r_ptr       <= '0;
        r_count     <= '0;
        r_full      <= 1'b0;
        r_overrun   <= 1'b0;
        r_stop_pend <= 1'b0;
      end
      if (w_rescan) begin
        r_pending <= ch_mask;
      end
      if (w_set_ovr) begin
        r_overrun <= 1'b1;
      end
      if (w_stop_set) begin
        r_stop_pend <= 1'b1;
      end
      if (w_write) begin
        r_pending <= w_remain;
        r_wr_addr <= r_ptr;
        r_wr_data <= w_sel_data;
        r_wr_ch   <= w_sel_idx;
        r_ptr     <= w_ptr_nxt;
        r_count   <= w_count_nxt;
        r_full    <= (w_count_nxt == CNT_FULL);
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign wr_ch   = r_wr_ch;
  assign count   = r_count;
  assign full    = r_full;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_daq_multi_seq.sv
// Directed self-checking bench for daq_multi_seq (DATA_W=8, CH_N=4, DEPTH=8).
module tb_daq_multi_seq;

  logic        new_clk;
  logic        reset;
  logic        load;
  logic        stop;
  logic        mode;
  logic [3:0]  ch_mask;
  logic [31:0] ch_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  wr_ch;
  logic [3:0]  count;
  logic        full;
  logic        busy;
  logic        done;
  logic        overrun;

  int errorCount = 0;
  int checkCount = 0;

  daq_multi_seq #(.DATA_W(8), .CH_N(4), .DEPTH(8)) dut (
    .new_clk (new_clk),
    .reset   (reset),
    .load    (load),
    .stop    (stop),
    .mode    (mode),
    .ch_mask (ch_mask),
    .ch_data (ch_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ch   (wr_ch),
    .count   (count),
    .full    (full),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  initial new_clk = 1'b0;
  always #5 new_clk = ~new_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge new_clk);
    #1;
  endtask

  // Raise load for exactly one sampled edge, leaving it low afterwards.
  task automatic applyStimulus();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic checkWrite(input string tag, input int addr, input int data, input int ch, input int cnt);
    checkOutput({tag, "_en"},    wr_en,   1);
    checkOutput({tag, "_addr"},  wr_addr, addr);
    checkOutput({tag, "_data"},  wr_data, data);
    checkOutput({tag, "_ch"},    wr_ch,   ch);
    checkOutput({tag, "_count"}, count,   cnt);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; stop = 1'b0; mode = 1'b0;
    ch_mask = 4'b0000; ch_data = 32'h0;

    // Reset and held-load behaviour.
    #3;
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_addr", wr_addr, 0);
    checkOutput("rst_data", wr_data, 0);
    checkOutput("rst_ch", wr_ch, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_flags", {full, busy, done, overrun}, 0);
    #9;
    reset = 1'b0;
    step();
    load = 1'b1;
    step();
    checkOutput("zero_mask_busy", busy, 0);
    ch_mask = 4'b1111;
    step();
    step();
    checkOutput("held_load_busy", busy, 0);
    checkOutput("held_load_wr", wr_en, 0);
    load = 1'b0;
    step();

    // Single-shot, sparse mask.
    mode = 1'b0; ch_mask = 4'b0101; ch_data = 32'h44332211;
    applyStimulus();
    checkOutput("ss_lat_wr", wr_en, 0);
    checkOutput("ss_lat_busy", busy, 1);
    step(); checkWrite("ss_w0", 0, 8'h11, 0, 1);
    step(); checkWrite("ss_w1", 1, 8'h33, 2, 2);
    step();
    checkOutput("ss_wait_wr", wr_en, 0);
    checkOutput("ss_wait_count", count, 2);
    applyStimulus();
    step(); checkWrite("ss_w2", 2, 8'h11, 0, 3);
    step(); checkWrite("ss_w3", 3, 8'h33, 2, 4);
    step();
    applyStimulus();
    step(); checkWrite("ss_w4", 4, 8'h11, 0, 5);
    step(); checkWrite("ss_w5", 5, 8'h33, 2, 6);
    step();
    applyStimulus();
    step(); checkWrite("ss_w6", 6, 8'h11, 0, 7);
    checkOutput("ss_w6_done", done, 0);
    step(); checkWrite("ss_w7", 7, 8'h33, 2, 8);
    checkOutput("ss_w7_done", done, 1);
    checkOutput("ss_w7_full", full, 1);
    step();
    checkOutput("ss_end_busy", busy, 0);
    checkOutput("ss_end_done", done, 0);
    checkOutput("ss_end_full", full, 1);
    checkOutput("ss_end_count", count, 8);

    // Single-shot truncation of the last scan.
    ch_mask = 4'b0111; ch_data = 32'hDDCCBBAA;
    applyStimulus();
    step(); checkWrite("tr_w0", 0, 8'hAA, 0, 1);
    checkOutput("tr_w0_full", full, 0);
    step(); checkWrite("tr_w1", 1, 8'hBB, 1, 2);
    step(); checkWrite("tr_w2", 2, 8'hCC, 2, 3);
    applyStimulus();
    step(); checkWrite("tr_w3", 3, 8'hAA, 0, 4);
    step(); checkWrite("tr_w4", 4, 8'hBB, 1, 5);
    step(); checkWrite("tr_w5", 5, 8'hCC, 2, 6);
    applyStimulus();
    step(); checkWrite("tr_w6", 6, 8'hAA, 0, 7);
    step(); checkWrite("tr_w7", 7, 8'hBB, 1, 8);
    checkOutput("tr_w7_done", done, 1);
    step();
    checkOutput("tr_drop_wr", wr_en, 0);
    checkOutput("tr_drop_busy", busy, 0);

    // Continuous wrap, then stop during the scan.
    mode = 1'b1; ch_mask = 4'b0011;
    for (int s = 0; s < 5; s++) begin
      applyStimulus();
      step(); checkWrite("ct_a", (2*s) % 8, 8'hAA, 0, (2*s+1 > 8) ? 8 : 2*s+1);
      step(); checkWrite("ct_b", (2*s+1) % 8, 8'hBB, 1, (2*s+2 > 8) ? 8 : 2*s+2);
      checkOutput("ct_done", done, 0);
    end
    checkOutput("ct_full", full, 1);
    applyStimulus();
    stop = 1'b1;
    step(); checkWrite("ct_stop_a", 2, 8'hAA, 0, 8);
    stop = 1'b0;
    step(); checkWrite("ct_stop_b", 3, 8'hBB, 1, 8);
    checkOutput("ct_stop_done", done, 1);
    step();
    checkOutput("ct_end_done", done, 0);
    checkOutput("ct_end_busy", busy, 0);
    checkOutput("ct_end_full", full, 1);

    // Overrun during a 4-channel scan, stop from WAIT, zero-mask trigger.
    ch_mask = 4'b1111; ch_data = 32'h44332211;
    applyStimulus();
    step(); checkWrite("ov_w0", 0, 8'h11, 0, 1);
    load = 1'b1;
    step(); checkWrite("ov_w1", 1, 8'h22, 1, 2);
    checkOutput("ov_set", overrun, 1);
    load = 1'b0;
    step(); checkWrite("ov_w2", 2, 8'h33, 2, 3);
    step(); checkWrite("ov_w3", 3, 8'h44, 3, 4);
    stop = 1'b1;
    step();
    checkOutput("ov_wait_stop_wr", wr_en, 0);
    checkOutput("ov_wait_stop_done", done, 1);
    stop = 1'b0;
    step();
    checkOutput("ov_idle_busy", busy, 0);
    checkOutput("ov_sticky", overrun, 1);
    checkOutput("ov_idle_count", count, 4);
    ch_mask = 4'b0000;
    applyStimulus();
    checkOutput("zm_busy", busy, 0);
    step();
    checkOutput("zm_busy2", busy, 0);
    checkOutput("zm_wr", wr_en, 0);
    checkOutput("zm_overrun", overrun, 1);
    mode = 1'b0; ch_mask = 4'b0001;
    applyStimulus();
    checkOutput("ov_clr_busy", busy, 1);
    checkOutput("ov_clr", overrun, 0);
    step(); checkWrite("ov_restart", 0, 8'h11, 0, 1);

    // Reset during the second write of a scan.
    ch_mask = 4'b0111;
    applyStimulus();
    step(); checkWrite("rm_w0", 1, 8'h11, 0, 2);
    step(); checkWrite("rm_w1", 2, 8'h22, 1, 3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rm_wr_en", wr_en, 0);
    checkOutput("rm_busy", busy, 0);
    checkOutput("rm_count", count, 0);
    checkOutput("rm_addr", wr_addr, 0);
    step();
    reset = 1'b0;
    step();
    checkOutput("rm_after_wr", wr_en, 0);
    checkOutput("rm_after_busy", busy, 0);
    ch_mask = 4'b0011;
    applyStimulus();
    step(); checkWrite("rm_restart", 0, 8'h11, 0, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
